// File: rtl/axi_full_fb_read_slave.sv
// AXI4 read-only slave streaming INCR/FIXED bursts out of a single-port framebuffer BRAM.
// Optional macro FB_RANGE_CHECK_EN: beats beyond FB_DEPTH skip the BRAM and return SLVERR.
//
// state    | meaning
// ST_IDLE  | ARREADY high, waiting for a burst
// ST_FETCH | BRAM_RE pulse for the current beat is on the BRAM port
// ST_CAPTURE | BRAM data valid, loaded into RDATA with RVALID
// ST_SEND  | beat presented, waiting for RREADY
module axi_full_fb_read_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_TARGET_BASE_ADDR = '0,
  parameter int BRAM_ADDR_WIDTH = 17,
  parameter int PIXEL_WIDTH = 16,
  parameter int FB_DEPTH = 76800
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [BRAM_ADDR_WIDTH-1:0]      BRAM_RDADDR,
  output logic                            BRAM_RE,
  input  logic [PIXEL_WIDTH-1:0]          BRAM_DATA_IN,
  output logic                            BUSY
);

  localparam int ADDR_LSB = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int WORD_W   = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_CAPTURE, ST_SEND} state_t;

  state_t                          r_state, w_state_nxt;
  logic [WORD_W-1:0]               r_word, w_word_nxt;
  logic [7:0]                      r_len, w_len_nxt;
  logic [7:0]                      r_beat, w_beat_nxt;
  logic                            r_fixed, w_fixed_nxt;
  logic                            r_arready, w_arready_nxt;
  logic                            r_rvalid, w_rvalid_nxt;
  logic                            r_rlast, w_rlast_nxt;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
  logic [1:0]                      r_rresp, w_rresp_nxt;
  logic                            r_re, w_re_nxt;
  logic [BRAM_ADDR_WIDTH-1:0]      r_rdaddr, w_rdaddr_nxt;
  logic                            r_busy, w_busy_nxt;
  logic                            w_issue;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_addr_off;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_pixel_ext;
  logic                            w_unused_ok;

  assign w_addr_off  = S_AXI_ARADDR - C_S_TARGET_BASE_ADDR;
  assign w_pixel_ext = C_S_AXI_DATA_WIDTH'(BRAM_DATA_IN);

`ifdef FB_RANGE_CHECK_EN
  localparam logic [WORD_W-1:0] FB_DEPTH_W = WORD_W'(FB_DEPTH);
  logic r_oor, w_oor_nxt;
  assign w_unused_ok = ^{S_AXI_ARSIZE, w_addr_off[ADDR_LSB-1:0]};
`else
  assign w_unused_ok = ^{S_AXI_ARSIZE, w_addr_off[ADDR_LSB-1:0], (FB_DEPTH != 0)};
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_word_nxt    = r_word;
    w_len_nxt     = r_len;
    w_beat_nxt    = r_beat;
    w_fixed_nxt   = r_fixed;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_re_nxt      = 1'b0;
    w_rdaddr_nxt  = r_rdaddr;
    w_busy_nxt    = r_busy;
    w_issue       = 1'b0;
`ifdef FB_RANGE_CHECK_EN
    w_oor_nxt     = r_oor;
`endif
    case (r_state)
      ST_IDLE: begin
        w_arready_nxt = 1'b1;
        if (S_AXI_ARVALID && r_arready) begin
          w_word_nxt    = w_addr_off[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
          w_len_nxt     = S_AXI_ARLEN;
          w_fixed_nxt   = (S_AXI_ARBURST == 2'b00);
          w_beat_nxt    = 8'd0;
          w_arready_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_issue       = 1'b1;
        end
      end
      ST_FETCH: w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
`ifdef FB_RANGE_CHECK_EN
        w_rdata_nxt = r_oor ? '0 : w_pixel_ext;
        w_rresp_nxt = r_oor ? 2'b10 : 2'b00;
`else
        w_rdata_nxt = w_pixel_ext;
        w_rresp_nxt = 2'b00;
`endif
        w_rvalid_nxt = 1'b1;
        w_rlast_nxt  = (r_beat == r_len);
        w_state_nxt  = ST_SEND;
      end
      ST_SEND: begin
        if (S_AXI_RREADY) begin
          w_rvalid_nxt = 1'b0;
          if (r_rlast) begin
            w_rlast_nxt   = 1'b0;
            w_busy_nxt    = 1'b0;
            w_arready_nxt = 1'b1;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_beat_nxt = r_beat + 8'd1;
            w_word_nxt = r_fixed ? r_word : r_word + WORD_W'(1);
            w_issue    = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // BRAM port is driven from the next word so BRAM_RE lands the cycle after the decision.
    if (w_issue) begin
      w_state_nxt  = ST_FETCH;
      w_rdaddr_nxt = w_word_nxt[BRAM_ADDR_WIDTH-1:0];
`ifdef FB_RANGE_CHECK_EN
      w_oor_nxt    = (w_word_nxt >= FB_DEPTH_W);
      w_re_nxt     = !w_oor_nxt;
`else
      w_re_nxt     = 1'b1;
`endif
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_fixed   <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_re      <= 1'b0;
      r_rdaddr  <= '0;
      r_busy    <= 1'b0;
`ifdef FB_RANGE_CHECK_EN
      r_oor     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_word    <= w_word_nxt;
      r_len     <= w_len_nxt;
      r_beat    <= w_beat_nxt;
      r_fixed   <= w_fixed_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_re      <= w_re_nxt;
      r_rdaddr  <= w_rdaddr_nxt;
      r_busy    <= w_busy_nxt;
`ifdef FB_RANGE_CHECK_EN
      r_oor     <= w_oor_nxt;
`endif
    end
  end

  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign BRAM_RE       = r_re;
  assign BRAM_RDADDR   = r_rdaddr;
  assign BUSY          = r_busy;

endmodule

// File: tb/tb_axi_full_fb_read_slave.sv
// Directed bench for axi_full_fb_read_slave: latency, INCR/FIXED, backpressure, wrap, reset.
// Edge numbering: an output "at edge E" is first seen high when sampled at edge E.
module tb_axi_full_fb_read_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] S_AXI_ARADDR;
  logic [7:0]  S_AXI_ARLEN;
  logic [2:0]  S_AXI_ARSIZE;
  logic [1:0]  S_AXI_ARBURST;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RLAST;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [16:0] BRAM_RDADDR;
  logic        BRAM_RE;
  logic [15:0] BRAM_DATA_IN;
  logic        BUSY;

  axi_full_fb_read_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .BRAM_RDADDR(BRAM_RDADDR), .BRAM_RE(BRAM_RE), .BRAM_DATA_IN(BRAM_DATA_IN), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:131071];
  always @(posedge clk) if (BRAM_RE) BRAM_DATA_IN <= mem[BRAM_RDADDR];

  logic [16:0] re_addr[$];
  int          re_edge[$];
  always @(negedge clk) begin
    if (BRAM_RE) begin
      re_addr.push_back(BRAM_RDADDR);
      re_edge.push_back(cyc + 1);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input logic [16:0] a);
    return (a == 17'd0) ? 16'hABCD : (a[15:0] ^ 16'h5A5A);
  endfunction

  logic [16:0] exp_addr[$];
  logic [15:0] exp_data[$];
  logic [1:0]  exp_resp[$];

  task automatic plan_clear();
    exp_addr.delete(); exp_data.delete(); exp_resp.delete();
  endtask

  task automatic plan_beat(input logic [16:0] a, input bit oor);
    if (oor) begin
      exp_data.push_back(16'h0); exp_resp.push_back(2'b10);
    end else begin
      exp_addr.push_back(a); exp_data.push_back(pix(a)); exp_resp.push_back(2'b00);
    end
  endtask

  task automatic run_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_n);
    int t_hs, n, rv_edge, re0, k;
    logic [31:0] d0;
    logic l0;
    bit stable, extra;
    re0 = re_addr.size();
    rv_edge = 0;
    @(negedge clk);
    S_AXI_ARADDR = addr; S_AXI_ARLEN = len; S_AXI_ARBURST = burst; S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    check({tag, " arready"}, 64'(S_AXI_ARREADY), 64'd1);
    t_hs = cyc + 1;
    @(posedge clk);
    #1 S_AXI_ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      @(negedge clk);
      n = 0;
      while (!S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
      if (!S_AXI_RVALID) begin
        check({tag, " rvalid timeout"}, 64'd0, 64'd1);
        break;
      end
      if (b == 0) begin
        rv_edge = cyc + 1;
        check({tag, " busy"}, 64'(BUSY), 64'd1);
      end
      if (b == stall_beat) begin
        S_AXI_RREADY = 1'b0;
        d0 = S_AXI_RDATA; l0 = S_AXI_RLAST; stable = 1'b1; k = re_addr.size();
        repeat (stall_n) begin
          @(negedge clk);
          if (!S_AXI_RVALID || S_AXI_RDATA !== d0 || S_AXI_RLAST !== l0) stable = 1'b0;
        end
        check({tag, " stall stable"}, 64'(stable), 64'd1);
        check({tag, " stall no re"}, 64'(re_addr.size() - k), 64'd0);
        S_AXI_RREADY = 1'b1;
      end
      check($sformatf("%s beat%0d data", tag, b), 64'(S_AXI_RDATA), 64'(exp_data[b]));
      check($sformatf("%s beat%0d last", tag, b), 64'(S_AXI_RLAST), 64'(b == int'(len)));
      check($sformatf("%s beat%0d resp", tag, b), 64'(S_AXI_RRESP), 64'(exp_resp[b]));
    end
    @(negedge clk);
    check({tag, " idle flags"}, 64'({S_AXI_ARREADY, BUSY, S_AXI_RVALID, S_AXI_RLAST}), 64'b1000);
    extra = 1'b0;
    repeat (6) begin @(negedge clk); if (S_AXI_RVALID) extra = 1'b1; end
    check({tag, " no extra beat"}, 64'(extra), 64'd0);
    check({tag, " re count"}, 64'(re_addr.size() - re0), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && re0 + i < re_addr.size(); i++)
      check($sformatf("%s re addr%0d", tag, i), 64'(re_addr[re0 + i]), 64'(exp_addr[i]));
    if (exp_addr.size() > 0 && re_addr.size() > re0)
      check({tag, " re latency"}, 64'(re_edge[re0] - t_hs), 64'd1);
    check({tag, " rvalid latency"}, 64'(rv_edge - t_hs), 64'd3);
  endtask

  initial begin
    int n;
    bit extra;
    for (int i = 0; i < 131072; i++) mem[i] = pix(17'(i));
    rst = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd2; S_AXI_ARBURST = 2'b01;
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    repeat (3) @(negedge clk);
    check("reset values",
          64'({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RDATA, S_AXI_RRESP, BRAM_RE, BRAM_RDADDR, BUSY}),
          64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("arready after reset", 64'(S_AXI_ARREADY), 64'd1);

    // 1: single beat from word 0
    plan_clear(); plan_beat(17'd0, 1'b0);
    run_burst("t1", 32'h0, 8'd0, 2'b01, -1, 0);

    // 2: 4-beat INCR from byte 0x10 -> words 4..7
    plan_clear();
    for (int i = 4; i < 8; i++) plan_beat(17'(i), 1'b0);
    run_burst("t2", 32'h10, 8'd3, 2'b01, -1, 0);

    // 3: same burst, master stalls 5 cycles on the second beat
    run_burst("t3", 32'h10, 8'd3, 2'b01, 1, 5);

    // 4: FIXED burst stays on word 8
    plan_clear();
    repeat (3) plan_beat(17'd8, 1'b0);
    run_burst("t4", 32'h20, 8'd2, 2'b00, -1, 0);

    // 5: WRAP behaves as INCR
    plan_clear();
    for (int i = 12; i < 14; i++) plan_beat(17'(i), 1'b0);
    run_burst("t5w", 32'h30, 8'd1, 2'b10, -1, 0);

`ifdef FB_RANGE_CHECK_EN
    // 6: second beat crosses the end of the framebuffer
    plan_clear(); plan_beat(17'd76799, 1'b0); plan_beat(17'd76800, 1'b1);
    run_burst("t6", 32'd307196, 8'd1, 2'b01, -1, 0);
`else
    // 5: word address wraps at the BRAM depth
    plan_clear();
    plan_beat(17'h1FFFE, 1'b0); plan_beat(17'h1FFFF, 1'b0);
    plan_beat(17'h00000, 1'b0); plan_beat(17'h00001, 1'b0);
    run_burst("t5", 32'h7FFF8, 8'd3, 2'b01, -1, 0);
`endif

    // 7: reset in the middle of an 8-beat burst
    @(negedge clk);
    S_AXI_ARADDR = 32'h40; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 20) begin @(negedge clk); n++; end
    check("t7 first beat data", 64'(S_AXI_RDATA), 64'(pix(17'h10)));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t7 reset values",
          64'({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST, S_AXI_RDATA, S_AXI_RRESP, BRAM_RE, BRAM_RDADDR, BUSY}),
          64'd0);
    rst = 1'b0;
    extra = 1'b0;
    repeat (8) begin @(negedge clk); if (S_AXI_RVALID || BRAM_RE) extra = 1'b1; end
    check("t7 burst abandoned", 64'(extra), 64'd0);
    check("t7 arready", 64'(S_AXI_ARREADY), 64'd1);
    plan_clear();
    for (int i = 4; i < 8; i++) plan_beat(17'(i), 1'b0);
    run_burst("t7 new", 32'h10, 8'd3, 2'b01, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
